// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the convolution result reader.
package conv_pkg;

    localparam int OUT_W_DEF  = 13;
    localparam int OUT_H_DEF  = 13;
    localparam int ADDR_W_DEF = 9;
    localparam int N_DEF      = OUT_W_DEF * OUT_H_DEF;
    localparam int NW_DEF     = (N_DEF + 3) / 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Counter width helper that never returns zero, so 1-entry ranges still get a real bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/conv_result_reader_word_unpacker.sv
// Holds one fetched 32-bit result word and presents its bytes little-endian, one at a time.
module word_unpacker (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_advance,
    input  logic [31:0] i_word,
    output logic [7:0]  o_byte,
    output logic [1:0]  o_byte_idx
);

    logic [31:0] r_word;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_byte;
    logic [1:0]  w_byte_idx_nxt;

    assign w_byte_idx_nxt = r_byte_idx + 2'd1;

    // Word capture and byte-index stepping; the offered byte is registered so it stays put under backpressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word     <= 32'd0;
            r_byte_idx <= 2'd0;
            r_byte     <= 8'd0;
        end else if (i_load) begin
            r_word     <= i_word;
            r_byte_idx <= 2'd0;
            r_byte     <= i_word[7:0];
        end else if (i_advance) begin
            r_byte_idx <= w_byte_idx_nxt;
            r_byte     <= r_word[{w_byte_idx_nxt, 3'b000} +: 8];
        end
    end

    assign o_byte     = r_byte;
    assign o_byte_idx = r_byte_idx;

endmodule

// File: rtl/conv_result_reader.sv
// Drains the packed convolution output map from result memory and streams it bytewise over valid/ready.
// Optional row-end flag out_eol is enabled by defining CONV_RESULT_READER_EOL_EN.
module conv_result_reader
    import conv_pkg::*;
#(
    parameter int OUT_W  = OUT_W_DEF,
    parameter int OUT_H  = OUT_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
`ifdef CONV_RESULT_READER_EOL_EN
    output logic              out_eol,
`endif
    output logic              busy,
    output logic              done
);

    localparam int N      = OUT_W * OUT_H;
    localparam int NW     = (N + 3) / 4;
    localparam int IDX_W  = clog2_min1(N);
    localparam int WIDX_W = clog2_min1(NW);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   w_base_nxt;
    logic [WIDX_W-1:0]   r_widx;
    logic [WIDX_W-1:0]   w_widx_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_xfer;
    logic                w_is_last;
    logic                w_load;
    logic                w_advance;
    logic [1:0]          w_byte_idx;
    logic [7:0]          w_byte;

    logic                r_mem_rd_en;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_busy;
    logic                r_done;

    assign w_xfer    = r_out_valid & out_ready;
    assign w_is_last = (r_idx == IDX_W'(N - 1));

    // Next-state, counter and unpacker-control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_widx_nxt  = r_widx;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_READ;
                    w_base_nxt  = base_addr;
                    w_widx_nxt  = {WIDX_W{1'b0}};
                    w_idx_nxt   = {IDX_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_nxt = ST_STREAM;
                w_load      = 1'b1;
            end
            ST_STREAM: begin
                if (w_xfer) begin
                    if (w_is_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                        if (w_byte_idx == 2'd3) begin
                            w_state_nxt = ST_READ;
                            w_widx_nxt  = r_widx + WIDX_W'(1);
                        end else begin
                            w_state_nxt = ST_STREAM;
                            w_advance   = 1'b1;
                        end
                    end
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Word offset is formed before truncation so the address wraps modulo 2^ADDR_W.
    assign w_rd_addr = w_base_nxt + ADDR_W'({w_widx_nxt, 2'b00});

    // State, counters and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_base      <= {ADDR_W{1'b0}};
            r_widx      <= {WIDX_W{1'b0}};
            r_idx       <= {IDX_W{1'b0}};
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_base      <= w_base_nxt;
            r_widx      <= w_widx_nxt;
            r_idx       <= w_idx_nxt;
            r_mem_rd_en <= (w_state_nxt == ST_READ);
            if (w_state_nxt == ST_READ) begin
                r_mem_addr <= w_rd_addr;
            end
            r_out_valid <= (w_state_nxt == ST_STREAM);
            r_out_last  <= (w_state_nxt == ST_STREAM) && (w_idx_nxt == IDX_W'(N - 1));
            r_busy      <= (w_state_nxt == ST_READ) || (w_state_nxt == ST_WAIT) ||
                           (w_state_nxt == ST_STREAM);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    word_unpacker u_unpacker (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_advance  (w_advance),
        .i_word     (mem_rdata),
        .o_byte     (w_byte),
        .o_byte_idx (w_byte_idx)
    );

`ifdef CONV_RESULT_READER_EOL_EN
    localparam int COL_W = clog2_min1(OUT_W);

    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_col_nxt;
    logic             r_out_eol;

    // Column position of the byte that will be offered next.
    always_comb begin
        w_col_nxt = r_col;
        if ((r_state == ST_IDLE) && start) begin
            w_col_nxt = {COL_W{1'b0}};
        end else if ((r_state == ST_STREAM) && w_xfer && !w_is_last) begin
            if (r_col == COL_W'(OUT_W - 1)) begin
                w_col_nxt = {COL_W{1'b0}};
            end else begin
                w_col_nxt = r_col + COL_W'(1);
            end
        end else begin
            w_col_nxt = r_col;
        end
    end

    // Row counter and row-end flag registered alongside out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= {COL_W{1'b0}};
            r_out_eol <= 1'b0;
        end else begin
            r_col     <= w_col_nxt;
            r_out_eol <= (w_state_nxt == ST_STREAM) && (w_col_nxt == COL_W'(OUT_W - 1));
        end
    end

    assign out_eol = r_out_eol;
`endif

    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;
    assign out_data  = w_byte;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_conv_result_reader.sv
// Randomized bench for conv_result_reader against a byte-addressed memory/stream reference model.
module tb_conv_result_reader;
    import conv_pkg::*;

    localparam int N         = N_DEF;
    localparam int NW        = NW_DEF;
    localparam int OUT_W     = OUT_W_DEF;
    localparam int ADDR_W    = ADDR_W_DEF;
    localparam int MEM_BYTES = 1 << ADDR_W;
    localparam int BUDGET    = 4000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;
`ifdef CONV_RESULT_READER_EOL_EN
    logic              out_eol;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]        mem_b [MEM_BYTES];
    logic [ADDR_W-1:0] cur_base;
    int                rx_cnt   = 0;
    int                rd_cnt   = 0;
    int                done_cnt = 0;
    bit                prev_stall = 1'b0;
    bit                prev_lastx = 1'b0;
    logic [7:0]        prev_data;
    logic              prev_last_o;

    conv_result_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef CONV_RESULT_READER_EOL_EN
        .out_eol   (out_eol),
`endif
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: result i is simply the memory byte at base+i, wrapping the address space.
    function automatic logic [7:0] exp_byte(input int i);
        return mem_b[(int'(cur_base) + i) % MEM_BYTES];
    endfunction

    // Memory returns data one cycle after the strobe; junk otherwise so late capture is caught.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= {mem_b[(int'(mem_addr) + 3) % MEM_BYTES], mem_b[(int'(mem_addr) + 2) % MEM_BYTES],
                          mem_b[(int'(mem_addr) + 1) % MEM_BYTES], mem_b[int'(mem_addr)]};
        end else begin
            mem_rdata <= $urandom;
        end
    end

    // Stream/memory monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check_value("hold_valid", 32'(out_valid), 32'd1);
                check_value("hold_data", 32'(out_data), 32'(prev_data));
                check_value("hold_last", 32'(out_last), 32'(prev_last_o));
            end
            if (done || prev_lastx) check_value("done_pulse", 32'(done), 32'(prev_lastx));
            if (done) begin
                done_cnt++;
                check_value("done_busy", 32'(busy), 32'd0);
            end
            if (out_valid || mem_rd_en) check_value("busy_active", 32'(busy), 32'd1);
            if (mem_rd_en) begin
                check_value("rd_addr", 32'(mem_addr), 32'((int'(cur_base) + 4 * rd_cnt) % MEM_BYTES));
                rd_cnt++;
            end
            prev_lastx = 1'b0;
            if (out_valid && out_ready) begin
                check_value("rx_in_range", 32'(rx_cnt < N), 32'd1);
                if (rx_cnt < N) check_value("data", 32'(out_data), 32'(exp_byte(rx_cnt)));
                check_value("last", 32'(out_last), 32'(rx_cnt == N - 1));
`ifdef CONV_RESULT_READER_EOL_EN
                check_value("eol", 32'(out_eol), 32'((rx_cnt % OUT_W) == OUT_W - 1));
`endif
                prev_lastx = (rx_cnt == N - 1);
                rx_cnt++;
            end
            prev_stall  = out_valid && !out_ready;
            prev_data   = out_data;
            prev_last_o = out_last;
        end else begin
            prev_stall = 1'b0;
            prev_lastx = 1'b0;
        end
    end

    task automatic check_all_zero(input string tag);
        check_value({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
        check_value({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check_value({tag, "_data"}, 32'(out_data), 32'd0);
        check_value({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_value({tag, "_last"}, 32'(out_last), 32'd0);
        check_value({tag, "_busy"}, 32'(busy), 32'd0);
        check_value({tag, "_done"}, 32'(done), 32'd0);
`ifdef CONV_RESULT_READER_EOL_EN
        check_value({tag, "_eol"}, 32'(out_eol), 32'd0);
`endif
    endtask

    // rmode: 0 always ready, 1 stall byte 7 for 5 cycles then random, 2 random.
    task automatic run_drain(input logic [ADDR_W-1:0] b, input int rmode, input bit inject, input bit abort);
        int budget;
        int done0;
        int stall;
        bit inj_s;
        @(posedge clk); #1;
        cur_base  = b;
        rx_cnt    = 0;
        rd_cnt    = 0;
        done0     = done_cnt;
        stall     = 0;
        inj_s     = 1'b0;
        base_addr = b;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
        budget    = 0;
        while (done_cnt == done0 && budget < BUDGET) begin
            if (abort && rx_cnt >= 51) break;
            case (rmode)
                0: out_ready = 1'b1;
                1: begin
                    if (rx_cnt == 7 && out_valid && stall < 5) begin
                        check_value("bp_byte7", 32'(out_data), 32'(exp_byte(7)));
                        out_ready = 1'b0;
                        stall++;
                    end else if (stall >= 5) begin
                        out_ready = 1'($urandom_range(0, 1));
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = 1'b0;
            if (inject && out_valid && rx_cnt == 20 && !inj_s) begin
                start = 1'b1;
                inj_s = 1'b1;
            end
            if (inject && done) start = 1'b1;
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        if (abort) begin
            check_value("abort_reached", 32'(rx_cnt >= 51), 32'd1);
        end else begin
            check_value("drain_timeout", 32'(budget < BUDGET), 32'd1);
            check_value("rx_count", 32'(rx_cnt), 32'(N));
            check_value("rd_count", 32'(rd_cnt), 32'(NW));
            if (rmode == 1) check_value("bp_stalls", 32'(stall), 32'd5);
            out_ready = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            check_value("single_done", 32'(done_cnt - done0), 32'd1);
            check_value("idle_busy", 32'(busy), 32'd0);
            check_value("idle_valid", 32'(out_valid), 32'd0);
            check_value("idle_rd_en", 32'(mem_rd_en), 32'd0);
        end
    endtask

    initial begin
        int done_before;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        out_ready = 1'b1;
        cur_base  = '0;
        for (int a = 0; a < MEM_BYTES; a++) mem_b[a] = 8'(a);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #1;
        rst = 1'b0;

        run_drain(ADDR_W'(0), 0, 1'b0, 1'b0);

        for (int a = 0; a < MEM_BYTES; a++) mem_b[a] = 8'($urandom);
        run_drain(ADDR_W'(0), 1, 1'b0, 1'b0);
        run_drain(ADDR_W'(500), 0, 1'b0, 1'b0);
        run_drain(ADDR_W'($urandom_range(0, MEM_BYTES / 4 - 1) * 4), 2, 1'b1, 1'b0);

        run_drain(ADDR_W'(100), 0, 1'b0, 1'b1);
        done_before = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("abort");
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_value("abort_no_done", 32'(done_cnt), 32'(done_before));
        run_drain(ADDR_W'(36), 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
